// File: rtl/seq_monitor.sv
// seq_monitor: receive-side checker for the sequencer's 7-bit one-hot phase
// vector. Re-encodes each sampled phase to a 3-bit index, checks the step
// against the hold / increment / reload-to-0 / reload-to-4 rules, locks onto
// a clean sequence, counts violations and latches a sticky fault when too
// many violations arrive back to back while locked.
module seq_monitor #(
  parameter int LOCK_LEN  = 4,
  parameter int FAULT_LIM = 3,
  parameter int ERR_W     = 8
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             en,
  input  logic             clr,
  input  logic [6:0]       p,
  output logic [2:0]       idx,
  output logic             code_ok,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [3:0]       LOCK_LEN_C  = 4'(LOCK_LEN);
  localparam logic [3:0]       FAULT_LIM_C = 4'(FAULT_LIM);
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [2:0]       prev, prev_n;
  logic [3:0]       run, run_n;
  logic [3:0]       miss, miss_n;
  logic             code_ok_n;
  logic             viol;
  logic [ERR_W-1:0] err_cnt_n;

  logic [2:0] enc_idx;
  logic       enc_valid;
  logic [2:0] ones;
  logic [2:0] prev_inc;
  logic       step_ok;

  // Encode p: one-hot bit k gives k, all-zero gives 7, multi-hot is invalid.
  always_comb begin
    enc_idx   = 3'd7;
    ones      = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (p[k]) begin
        ones    = ones + 3'd1;
        enc_idx = 3'(k);
      end
    end
    enc_valid = (ones <= 3'd1);
  end

  // A step is legal for hold, +1 modulo 8, reload to 0, or reload to 4 from 1.
  always_comb begin
    prev_inc = prev + 3'd1;
    step_ok  = (enc_idx == prev) || (enc_idx == prev_inc) ||
               (enc_idx == 3'd0) || ((enc_idx == 3'd4) && (prev == 3'd1));
  end

  // Next-state and next-output logic; nothing moves unless en samples outside FAULT.
  always_comb begin
    state_n   = state;
    prev_n    = prev;
    run_n     = run;
    miss_n    = miss;
    code_ok_n = code_ok;
    viol      = 1'b0;
    if (en && (state != FAULT)) begin
      code_ok_n = enc_valid;
      if (enc_valid) begin
        prev_n = enc_idx;
      end
      case (state)
        IDLE: begin
          if (enc_valid) begin
            run_n   = 4'd0;
            state_n = ACQ;
          end else begin
            viol = 1'b1;
          end
        end
        ACQ: begin
          if (enc_valid && step_ok) begin
            if (run + 4'd1 == LOCK_LEN_C) begin
              run_n   = 4'd0;
              state_n = LOCKED;
            end else begin
              run_n = run + 4'd1;
            end
          end else begin
            viol  = 1'b1;
            run_n = 4'd0;
          end
        end
        LOCKED: begin
          if (enc_valid && step_ok) begin
            miss_n = 4'd0;
          end else begin
            viol   = 1'b1;
            miss_n = miss + 4'd1;
            if (miss + 4'd1 == FAULT_LIM_C) begin
              state_n = FAULT;
            end
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
    err_cnt_n = (viol && (err_cnt != {ERR_W{1'b1}})) ? err_cnt + ERR_ONE : err_cnt;
  end

  // State and output registers; rs and clr both return everything to IDLE.
  always_ff @(posedge ck) begin
    if (rs || clr) begin
      state     <= IDLE;
      prev      <= 3'd0;
      run       <= 4'd0;
      miss      <= 4'd0;
      code_ok   <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      prev      <= prev_n;
      run       <= run_n;
      miss      <= miss_n;
      code_ok   <= code_ok_n;
      err_pulse <= viol;
      err_cnt   <= err_cnt_n;
    end
  end

  assign idx    = prev;
  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_seq_monitor.sv
// Testbench for seq_monitor: directed test-plan sequences followed by
// randomized traffic, all checked against a behavioural model. A second
// instance with a 2-bit error counter exercises counter saturation.
module tb_seq_monitor;

  localparam int LOCK_LEN  = 4;
  localparam int FAULT_LIM = 3;

  logic       ck;
  logic       rs;
  logic       en;
  logic       clr;
  logic [6:0] p;

  logic [2:0] idx, idx2;
  logic       code_ok, code_ok2;
  logic       locked, locked2;
  logic       fault, fault2;
  logic       err_pulse, err_pulse2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0=idle 1=acquiring 2=locked 3=fault
  int m_mode, m_prev, m_code_ok, m_run, m_miss, m_err, m_err2, m_pulse;

  seq_monitor #(.LOCK_LEN(LOCK_LEN), .FAULT_LIM(FAULT_LIM), .ERR_W(8)) dut (
    .ck(ck), .rs(rs), .en(en), .clr(clr), .p(p),
    .idx(idx), .code_ok(code_ok), .locked(locked), .fault(fault),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  seq_monitor #(.LOCK_LEN(LOCK_LEN), .FAULT_LIM(FAULT_LIM), .ERR_W(2)) dut_sat (
    .ck(ck), .rs(rs), .en(en), .clr(clr), .p(p),
    .idx(idx2), .code_ok(code_ok2), .locked(locked2), .fault(fault2),
    .err_pulse(err_pulse2), .err_cnt(err_cnt2)
  );

  // 10 ns clock
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] phaseVec(input int i);
    return (i == 7) ? 7'd0 : 7'(1 << i);
  endfunction

  // Model one clock edge straight from the transition rules.
  task automatic modelStep(input logic en_v, input logic clr_v, input logic rs_v, input logic [6:0] p_v);
    int  ones, newi;
    bit  valid, legal, bad;
    if (rs_v || clr_v) begin
      m_mode = 0; m_prev = 0; m_code_ok = 0; m_run = 0; m_miss = 0;
      m_err = 0; m_err2 = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (!en_v || m_mode == 3) return;
    ones  = $countones(p_v);
    valid = (ones <= 1);
    newi  = (ones == 0) ? 7 : $clog2(p_v);
    legal = valid && (newi == m_prev || newi == (m_prev + 1) % 8 || newi == 0 ||
                      (newi == 4 && m_prev == 1));
    bad   = !valid || (m_mode != 0 && !legal);
    m_code_ok = valid;
    if (valid) m_prev = newi;
    if (bad) begin
      m_pulse = 1;
      m_err   = (m_err  < 255) ? m_err  + 1 : 255;
      m_err2  = (m_err2 < 3)   ? m_err2 + 1 : 3;
    end
    case (m_mode)
      0: if (valid) begin m_mode = 1; m_run = 0; end
      1: if (bad) m_run = 0;
         else begin
           m_run++;
           if (m_run == LOCK_LEN) begin m_mode = 2; m_run = 0; end
         end
      2: if (bad) begin
           m_miss++;
           if (m_miss == FAULT_LIM) m_mode = 3;
         end else m_miss = 0;
      default: ;
    endcase
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".idx"},       32'(idx),       32'(m_prev));
    checkOutput({tag, ".code_ok"},   32'(code_ok),   32'(m_code_ok));
    checkOutput({tag, ".locked"},    32'(locked),    32'(m_mode == 2));
    checkOutput({tag, ".fault"},     32'(fault),     32'(m_mode == 3));
    checkOutput({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    checkOutput({tag, ".err_cnt"},   32'(err_cnt),   32'(m_err));
    checkOutput({tag, ".err_cnt2"},  32'(err_cnt2),  32'(m_err2));
    checkOutput({tag, ".pulse2"},    32'(err_pulse2), 32'(m_pulse));
  endtask

  task automatic applyStimulus(input string tag, input logic en_v, input logic clr_v,
                               input logic rs_v, input logic [6:0] p_v);
    @(negedge ck);
    en = en_v; clr = clr_v; rs = rs_v; p = p_v;
    @(posedge ck);
    modelStep(en_v, clr_v, rs_v, p_v);
    #1;
    checkAll(tag);
  endtask

  task automatic sample(input string tag, input int i);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, phaseVec(i));
  endtask

  initial begin
    int r, ni;
    logic [6:0] pv;
    rs = 1'b1; clr = 1'b0; en = 1'b0; p = 7'd0;
    m_mode = 0; m_prev = 0; m_code_ok = 0; m_run = 0; m_miss = 0;
    m_err = 0; m_err2 = 0; m_pulse = 0;

    applyStimulus("reset", 1'b0, 1'b0, 1'b1, 7'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);

    // Lock onto 0,1,2,3,4
    for (int i = 0; i < 5; i++) sample("lock", i);
    checkOutput("lock_locked", 32'(locked), 32'd1);
    checkOutput("lock_err_cnt", 32'(err_cnt), 32'd0);

    // Illegal jump 5 -> 1, then reload 0 clears miss
    sample("jump5", 5);
    sample("jump1", 1);
    checkOutput("jump_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("jump_locked", 32'(locked), 32'd1);
    sample("reload0", 0);

    // Reload to 4 from 1 is legal, from 2 is not
    sample("to1", 1);
    sample("r4ok", 4);
    checkOutput("r4ok_pulse", 32'(err_pulse), 32'd0);
    sample("z0", 0); sample("z1", 1); sample("z2", 2);
    sample("r4bad", 4);
    checkOutput("r4bad_pulse", 32'(err_pulse), 32'd1);
    sample("r5", 5);

    // Three multi-hot samples force fault; further samples are ignored
    for (int i = 0; i < 3; i++) applyStimulus("multi", 1'b1, 1'b0, 1'b0, 7'b0000011);
    checkOutput("multi_fault", 32'(fault), 32'd1);
    checkOutput("multi_idx", 32'(idx), 32'd5);
    checkOutput("multi_err_cnt", 32'(err_cnt), 32'd5);
    for (int i = 0; i < 3; i++) applyStimulus("fault_hold", 1'b1, 1'b0, 1'b0, 7'b1100011);
    applyStimulus("clr", 1'b1, 1'b1, 1'b0, 7'b0000011);
    checkOutput("clr_fault", 32'(fault), 32'd0);

    // Re-lock, then hold en low with garbage on p
    for (int i = 2; i < 8; i++) sample("relock", i);
    for (int i = 0; i < 10; i++) applyStimulus("en_low", 1'b0, 1'b0, 1'b0, 7'($urandom));
    applyStimulus("rs_clr", 1'b1, 1'b1, 1'b1, 7'b0000001);
    checkOutput("rs_clr_code_ok", 32'(code_ok), 32'd0);

    // Saturation: five violations while acquiring
    sample("sat_start", 0);
    for (int i = 0; i < 5; i++) applyStimulus("sat", 1'b1, 1'b0, 1'b0, 7'b0101000);
    checkOutput("sat_err_cnt2", 32'(err_cnt2), 32'd3);

    // Randomized traffic biased toward legal sequences
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      ni = (m_prev + 1) % 8;
      else if (r < 60) ni = m_prev;
      else if (r < 70) ni = 0;
      else if (r < 75) ni = 4;
      else             ni = $urandom_range(0, 7);
      pv = phaseVec(ni);
      if ($urandom_range(0, 99) < 10) pv = pv | 7'(1 << $urandom_range(0, 6)) | 7'(1 << $urandom_range(0, 6));
      applyStimulus("rand", ($urandom_range(0, 99) < 85), ($urandom_range(0, 199) < 3),
                    ($urandom_range(0, 199) < 2), pv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
